// File: rtl/rf_wport_if.sv
// rtl/rf_wport_if.sv - WB/MDU request, RF write and scoreboard signals of the write-port arbiter
interface rf_wport_if;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    modport master (
        output p_we, p_waddr, p_wdata, mdu_valid, mdu_waddr, mdu_wdata,
               mdu_issue, mdu_issue_addr,
        input  pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  p_we, p_waddr, p_wdata, mdu_valid, mdu_waddr, mdu_wdata,
               mdu_issue, mdu_issue_addr,
        output pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - RF write-port arbiter between WB and MDU with pending-write scoreboard
module rf_wport_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    rf_wport_if.slave   bus
);
    typedef enum logic {ST_NORMAL, ST_FORCE} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q;
    logic [31:0]      rf_wdata_q;
    logic [31:0]      busy_q, busy_d;
    logic             preq, grant_p, grant_m;

    always_comb begin
        state_d = ST_NORMAL;
        cnt_d   = '0;
        grant_p = 1'b0;
        grant_m = 1'b0;
        preq    = bus.p_we && (bus.p_waddr != 5'd0);
        case (state_q)
            ST_NORMAL: begin
                if (preq) begin
                    grant_p = 1'b1;
                    if (bus.mdu_valid) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_d = ST_FORCE;
                    end
                end else if (bus.mdu_valid) begin
                    grant_m = 1'b1;
                end
            end
            ST_FORCE: begin
                // A dropped mdu_valid here is a protocol violation; let WB through
                if (bus.mdu_valid) grant_m = 1'b1;
                else if (preq)     grant_p = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (grant_m) busy_d[bus.mdu_waddr] = 1'b0;
        if (bus.mdu_issue && (bus.mdu_issue_addr != 5'd0)) busy_d[bus.mdu_issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            busy_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            if (grant_m) begin
                // MDU handshake to r0 retires the op without touching the RF
                rf_we_q <= (bus.mdu_waddr != 5'd0);
                if (bus.mdu_waddr != 5'd0) begin
                    rf_waddr_q <= bus.mdu_waddr;
                    rf_wdata_q <= bus.mdu_wdata;
                end
            end else if (grant_p) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.p_waddr;
                rf_wdata_q <= bus.p_wdata;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.mdu_ready  = grant_m && !rst;
    assign bus.pipe_stall = grant_m && preq && !rst;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.busy       = busy_q;
endmodule
